noc_pmu_counter_bank: RTL and testbench



---
 rtl/noc_pmu_counter_bank.sv | 161 ++++++++++++++++
 tb/tb_noc_pmu_counter_bank.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_pmu_counter_bank.sv
// Per-tile PMU event counters with control, W1C overflow status and irq mask,
// accessed over a one-outstanding request/response register port.
module noc_pmu_counter_bank #(
    parameter int unsigned TILE_COUNT    = 1,
    parameter int unsigned EVENT_COUNT   = 23,
    parameter int unsigned COUNTER_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH    = $clog2(TILE_COUNT) + 5
) (
    input  logic                              noc_clk,
    input  logic                              rst,
    input  logic [TILE_COUNT*EVENT_COUNT-1:0] pmu_sig_i,
    input  logic                              req_valid_i,
    output logic                              req_ready_o,
    input  logic                              req_write_i,
    input  logic [ADDR_WIDTH-1:0]             req_addr_i,
    input  logic [63:0]                       req_wdata_i,
    output logic                              rsp_valid_o,
    input  logic                              rsp_ready_i,
    output logic [63:0]                       rsp_rdata_o,
    output logic                              rsp_err_o,
    output logic                              irq_o
);

    localparam logic [4:0] SlotCtrl = 5'd28;
    localparam logic [4:0] SlotOvf  = 5'd29;
    localparam logic [4:0] SlotMask = 5'd30;

    logic [COUNTER_WIDTH-1:0] cnt_q [TILE_COUNT][EVENT_COUNT];
    logic [COUNTER_WIDTH-1:0] cnt_d [TILE_COUNT][EVENT_COUNT];
    logic [EVENT_COUNT-1:0]   ovf_q [TILE_COUNT];
    logic [EVENT_COUNT-1:0]   ovf_d [TILE_COUNT];
    logic [EVENT_COUNT-1:0]   mask_q [TILE_COUNT];
    logic [EVENT_COUNT-1:0]   mask_d [TILE_COUNT];
    logic [TILE_COUNT-1:0]    en_q, en_d, frz_q, frz_d;

    logic        rsp_valid_q, rsp_valid_d;
    logic [63:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        irq_q, irq_d;

    logic        req_acc;
    logic [4:0]  slot;
    int unsigned tile_idx;
    logic        tile_hit, slot_ok, dec_err;
    logic [63:0] rd_data;

    assign req_ready_o = !rsp_valid_q;
    assign req_acc     = req_valid_i && !rsp_valid_q;
    assign slot        = req_addr_i[4:0];
    assign tile_idx    = 32'(req_addr_i) >> 5;
    assign tile_hit    = tile_idx < TILE_COUNT;
    assign slot_ok     = (32'(slot) < EVENT_COUNT) || (slot == SlotCtrl) ||
                         (slot == SlotOvf) || (slot == SlotMask);
    assign dec_err     = !(tile_hit && slot_ok);

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign irq_o       = irq_q;

    always_comb begin
        rd_data = '0;
        for (int t = 0; t < TILE_COUNT; t++) begin
            if (tile_idx == unsigned'(t)) begin
                if (slot == SlotCtrl) begin
                    rd_data = {61'd0, frz_q[t], 1'b0, en_q[t]};
                end else if (slot == SlotOvf) begin
                    rd_data = 64'(ovf_q[t]);
                end else if (slot == SlotMask) begin
                    rd_data = 64'(mask_q[t]);
                end else begin
                    for (int e = 0; e < EVENT_COUNT; e++) begin
                        if (slot == 5'(e)) rd_data = 64'(cnt_q[t][e]);
                    end
                end
            end
        end
    end

    always_comb begin
        logic wr_tile, clr, frozen, wr_cnt, inc;
        wr_tile     = 1'b0;
        clr         = 1'b0;
        frozen      = 1'b0;
        wr_cnt      = 1'b0;
        inc         = 1'b0;
        irq_d       = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        if (rsp_valid_q && rsp_ready_i) rsp_valid_d = 1'b0;
        if (req_acc) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = dec_err;
            rsp_rdata_d = (dec_err || req_write_i) ? 64'd0 : rd_data;
        end

        for (int t = 0; t < TILE_COUNT; t++) begin
            wr_tile   = req_acc && req_write_i && !dec_err && (tile_idx == unsigned'(t));
            clr       = wr_tile && (slot == SlotCtrl) && req_wdata_i[1];
            frozen    = frz_q[t] && |(ovf_q[t] & mask_q[t]);
            en_d[t]   = en_q[t];
            frz_d[t]  = frz_q[t];
            mask_d[t] = mask_q[t];
            ovf_d[t]  = ovf_q[t];
            if (wr_tile && slot == SlotCtrl) begin
                en_d[t]  = req_wdata_i[0];
                frz_d[t] = req_wdata_i[2];
            end
            if (wr_tile && slot == SlotMask) mask_d[t] = req_wdata_i[EVENT_COUNT-1:0];

            for (int e = 0; e < EVENT_COUNT; e++) begin
                wr_cnt      = wr_tile && (slot == 5'(e));
                inc         = en_q[t] && pmu_sig_i[t*EVENT_COUNT+e] && !frozen;
                cnt_d[t][e] = cnt_q[t][e];
                if (wr_tile && slot == SlotOvf && req_wdata_i[e]) ovf_d[t][e] = 1'b0;
                // Wrap set is applied after W1C so a same-cycle wrap keeps the bit.
                if (clr) begin
                    cnt_d[t][e] = '0;
                    ovf_d[t][e] = 1'b0;
                end else if (wr_cnt) begin
                    cnt_d[t][e] = req_wdata_i[COUNTER_WIDTH-1:0];
                end else if (inc) begin
                    cnt_d[t][e] = cnt_q[t][e] + 1'b1;
                    if (&cnt_q[t][e]) ovf_d[t][e] = 1'b1;
                end
            end
            irq_d = irq_d | (|(ovf_q[t] & mask_q[t]));
        end
    end

    always_ff @(posedge noc_clk or negedge rst) begin
        if (!rst) begin
            for (int t = 0; t < TILE_COUNT; t++) begin
                for (int e = 0; e < EVENT_COUNT; e++) cnt_q[t][e] <= '0;
                ovf_q[t]  <= '0;
                mask_q[t] <= '0;
            end
            en_q        <= '1;
            frz_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            for (int t = 0; t < TILE_COUNT; t++) begin
                for (int e = 0; e < EVENT_COUNT; e++) cnt_q[t][e] <= cnt_d[t][e];
                ovf_q[t]  <= ovf_d[t];
                mask_q[t] <= mask_d[t];
            end
            en_q        <= en_d;
            frz_q       <= frz_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            irq_q       <= irq_d;
        end
    end

endmodule

// File: tb/tb_noc_pmu_counter_bank.sv
// Directed bench for noc_pmu_counter_bank: register table plus multi-cycle
// sequences for counting, wrap/irq, freeze, priority, errors, stall and reset.
module tb_noc_pmu_counter_bank;

    localparam int unsigned TC = 3;
    localparam int unsigned EC = 8;
    localparam int unsigned CW = 8;
    localparam int unsigned AW = 7;

    logic           noc_clk;
    logic           rst;
    logic [TC*EC-1:0] pmu_sig_i;
    logic           req_valid_i;
    logic           req_ready_o;
    logic           req_write_i;
    logic [AW-1:0]  req_addr_i;
    logic [63:0]    req_wdata_i;
    logic           rsp_valid_o;
    logic           rsp_ready_i;
    logic [63:0]    rsp_rdata_o;
    logic           rsp_err_o;
    logic           irq_o;

    noc_pmu_counter_bank #(
        .TILE_COUNT   (TC),
        .EVENT_COUNT  (EC),
        .COUNTER_WIDTH(CW),
        .ADDR_WIDTH   (AW)
    ) dut (
        .noc_clk    (noc_clk),
        .rst        (rst),
        .pmu_sig_i  (pmu_sig_i),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_write_i(req_write_i),
        .req_addr_i (req_addr_i),
        .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o  (rsp_err_o),
        .irq_o      (irq_o)
    );

    initial noc_clk = 1'b0;
    always #5 noc_clk = ~noc_clk;

    typedef struct {
        logic        wr;
        logic [6:0]  addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    int n_vec = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_req(input logic wr, input logic [6:0] addr, input logic [63:0] wd,
                          input bit drop_sig, output logic [63:0] rd, output logic er);
        int n;
        n = 0;
        while (!req_ready_o && n < 20) begin
            @(posedge noc_clk); #1;
            n++;
        end
        check("req_ready_before_req", {63'd0, req_ready_o}, 64'd1);
        req_valid_i = 1'b1;
        req_write_i = wr;
        req_addr_i  = addr;
        req_wdata_i = wd;
        @(posedge noc_clk); #1;
        req_valid_i = 1'b0;
        if (drop_sig) pmu_sig_i = '0;
        check("rsp_latency", {63'd0, rsp_valid_o}, 64'd1);
        rd = rsp_rdata_o;
        er = rsp_err_o;
        if (rsp_ready_i) begin
            @(posedge noc_clk); #1;
        end
    endtask

    task automatic rd_chk(input string name, input logic [6:0] addr, input logic [63:0] exp);
        logic [63:0] rd;
        logic        er;
        do_req(1'b0, addr, 64'd0, 1'b0, rd, er);
        check({name, "_rdata"}, rd, exp);
        check({name, "_err"}, {63'd0, er}, 64'd0);
    endtask

    task automatic wr_reg(input logic [6:0] addr, input logic [63:0] wd, input bit drop_sig);
        logic [63:0] rd;
        logic        er;
        do_req(1'b1, addr, wd, drop_sig, rd, er);
        check("write_err", {63'd0, er}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    vec_t tbl [21];

    initial begin
        tbl[0]  = '{1'b0, 7'd28,  64'd0, 64'd1, 1'b0};
        tbl[1]  = '{1'b0, 7'd92,  64'd0, 64'd1, 1'b0};
        tbl[2]  = '{1'b0, 7'd29,  64'd0, 64'd0, 1'b0};
        tbl[3]  = '{1'b0, 7'd62,  64'd0, 64'd0, 1'b0};
        tbl[4]  = '{1'b0, 7'd39,  64'd0, 64'd0, 1'b0};
        tbl[5]  = '{1'b1, 7'd62,  64'hFFFF_FFFF_FFFF_FFA5, 64'd0, 1'b0};
        tbl[6]  = '{1'b0, 7'd62,  64'd0, 64'hA5, 1'b0};
        tbl[7]  = '{1'b1, 7'd62,  64'd0, 64'd0, 1'b0};
        tbl[8]  = '{1'b0, 7'd62,  64'd0, 64'd0, 1'b0};
        tbl[9]  = '{1'b1, 7'd92,  64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0};
        tbl[10] = '{1'b0, 7'd92,  64'd0, 64'h5, 1'b0};
        tbl[11] = '{1'b1, 7'd92,  64'd1, 64'd0, 1'b0};
        tbl[12] = '{1'b1, 7'd71,  64'h1234, 64'd0, 1'b0};
        tbl[13] = '{1'b0, 7'd71,  64'd0, 64'h34, 1'b0};
        tbl[14] = '{1'b0, 7'd31,  64'd0, 64'd0, 1'b1};
        tbl[15] = '{1'b0, 7'd8,   64'd0, 64'd0, 1'b1};
        tbl[16] = '{1'b0, 7'd96,  64'd0, 64'd0, 1'b1};
        tbl[17] = '{1'b1, 7'd91,  64'hFF, 64'd0, 1'b1};
        tbl[18] = '{1'b1, 7'd127, 64'hFF, 64'd0, 1'b1};
        tbl[19] = '{1'b0, 7'd71,  64'd0, 64'h34, 1'b0};
        tbl[20] = '{1'b0, 7'd93,  64'd0, 64'd0, 1'b0};

        rst         = 1'b0;
        pmu_sig_i   = '0;
        req_valid_i = 1'b0;
        req_write_i = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        rsp_ready_i = 1'b1;

        // Reset values, checked while reset is held
        #3;
        check("reset_req_ready", {63'd0, req_ready_o}, 64'd1);
        check("reset_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
        check("reset_rsp_rdata", rsp_rdata_o, 64'd0);
        check("reset_irq", {63'd0, irq_o}, 64'd0);
        repeat (2) @(posedge noc_clk);
        #1 rst = 1'b1;
        @(posedge noc_clk); #1;

        // Level counting: 10 high cycles on tile 0 event 3
        pmu_sig_i = 24'h8;
        repeat (10) @(posedge noc_clk);
        #1 pmu_sig_i = '0;
        rd_chk("count10", 7'd3, 64'd10);

        for (int i = 0; i < 21; i++) begin
            logic [63:0] rd;
            logic        er;
            do_req(tbl[i].wr, tbl[i].addr, tbl[i].wdata, 1'b0, rd, er);
            check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
            check($sformatf("tbl%0d_err", i), {63'd0, er}, {63'd0, tbl[i].exp_err});
        end

        // Wrap of 8-bit counter on tile 1 event 0 with mask enabled
        wr_reg(7'd32, 64'hFE, 1'b0);
        wr_reg(7'd62, 64'h1, 1'b0);
        pmu_sig_i = 24'h100;
        @(posedge noc_clk);
        @(posedge noc_clk);
        #1 pmu_sig_i = '0;
        check("irq_not_yet", {63'd0, irq_o}, 64'd0);
        @(posedge noc_clk); #1;
        check("irq_after_wrap", {63'd0, irq_o}, 64'd1);
        rd_chk("wrap_cnt", 7'd32, 64'd0);
        rd_chk("wrap_ovf", 7'd61, 64'd1);
        wr_reg(7'd61, 64'h1, 1'b0);
        check("irq_after_w1c", {63'd0, irq_o}, 64'd0);
        rd_chk("ovf_cleared", 7'd61, 64'd0);

        // Freeze while masked overflow pending
        wr_reg(7'd60, 64'h5, 1'b0);
        wr_reg(7'd32, 64'hFF, 1'b0);
        pmu_sig_i = 24'h100;
        @(posedge noc_clk);
        #1 pmu_sig_i = 24'h300;
        repeat (5) @(posedge noc_clk);
        #1 pmu_sig_i = '0;
        check("frz_irq", {63'd0, irq_o}, 64'd1);
        rd_chk("frz_cnt_e1", 7'd33, 64'd0);
        rd_chk("frz_cnt_e0", 7'd32, 64'd0);
        pmu_sig_i = 24'h200;
        wr_reg(7'd61, 64'h1, 1'b0);
        pmu_sig_i = '0;
        rd_chk("frz_resume", 7'd33, 64'd1);
        wr_reg(7'd60, 64'h1, 1'b0);

        // Register write beats same-cycle increment
        pmu_sig_i = 24'h20;
        wr_reg(7'd5, 64'd100, 1'b1);
        rd_chk("wr_beats_inc", 7'd5, 64'd100);

        // Wrap set beats same-cycle W1C of that bit
        wr_reg(7'd0, 64'hFF, 1'b0);
        pmu_sig_i = 24'h1;
        wr_reg(7'd29, 64'h1, 1'b1);
        rd_chk("wrap_beats_w1c", 7'd29, 64'd1);
        rd_chk("race_cnt", 7'd0, 64'd0);

        // CLR with events high
        pmu_sig_i = 24'hFF;
        wr_reg(7'd28, 64'h3, 1'b1);
        rd_chk("clr_cnt5", 7'd5, 64'd0);
        rd_chk("clr_cnt3", 7'd3, 64'd0);
        rd_chk("clr_ovf", 7'd29, 64'd0);
        rd_chk("clr_ctrl", 7'd28, 64'd1);

        // Response stall: held stable, no new request accepted
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1;
        req_write_i = 1'b0;
        req_addr_i  = 7'd28;
        @(posedge noc_clk); #1;
        req_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("stall%0d_valid", i), {63'd0, rsp_valid_o}, 64'd1);
            check($sformatf("stall%0d_rdata", i), rsp_rdata_o, 64'd1);
            check($sformatf("stall%0d_ready", i), {63'd0, req_ready_o}, 64'd0);
            @(posedge noc_clk); #1;
        end
        rsp_ready_i = 1'b1;
        @(posedge noc_clk); #1;
        check("stall_release_valid", {63'd0, rsp_valid_o}, 64'd0);
        check("stall_release_ready", {63'd0, req_ready_o}, 64'd1);

        // Asynchronous reset with a response pending
        pmu_sig_i = 24'h8;
        repeat (3) @(posedge noc_clk);
        #1 pmu_sig_i = '0;
        rd_chk("pre_reset_cnt", 7'd3, 64'd3);
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1;
        req_write_i = 1'b0;
        req_addr_i  = 7'd3;
        @(posedge noc_clk); #1;
        req_valid_i = 1'b0;
        check("pend_valid", {63'd0, rsp_valid_o}, 64'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_valid", {63'd0, rsp_valid_o}, 64'd0);
        check("arst_rdata", rsp_rdata_o, 64'd0);
        check("arst_ready", {63'd0, req_ready_o}, 64'd1);
        @(posedge noc_clk); #1;
        rst = 1'b1;
        rsp_ready_i = 1'b1;
        @(posedge noc_clk); #1;
        rd_chk("post_rst_cnt3", 7'd3, 64'd0);
        rd_chk("post_rst_cnt_t2", 7'd71, 64'd0);
        rd_chk("post_rst_ctrl", 7'd28, 64'd1);
        rd_chk("post_rst_mask", 7'd62, 64'd0);
        check("post_rst_irq", {63'd0, irq_o}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
